// File: rtl/srt_div_ctrl_pkg.sv
// Shared types for the radix-2 SRT divider controller: FSM states, adder/quotient
// mux select encodings and the packed control word driven onto the datapath.
package srt_div_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, CLEAR, LOAD, NORM, NOTD, ITER, SAVE, CHECK, CORR, DENORM, DONE
    } state_t;

    // Left (remainder-side) adder operand selects
    localparam logic [1:0] ADD_SEL_CSA    = 2'b00;
    localparam logic [1:0] ADD_SEL_NOTD   = 2'b01;
    localparam logic [1:0] ADD_SEL_D      = 2'b10;
    localparam logic [1:0] ADD_SEL_NOTD_R = 2'b11;

    // Right (quotient-side) adder operand selects
    localparam logic [1:0] Q_SEL_CONV = 2'b00;
    localparam logic [1:0] Q_SEL_CORR = 2'b01;
    localparam logic [1:0] Q_SEL_INV  = 2'b10;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       div_by_zero;
        logic       divisor_en;
        logic       divisor_lshift;
        logic       notdivisor_en;
        logic       save_reminder;
        logic       sumh_mux_sel;
        logic       sum_en;
        logic       carry_en;
        logic       left_add_mode;
        logic       right_add_mode;
        logic       qcorrect_sel;
        logic       reminder_en;
        logic       reminder_rshift;
        logic       quotient_en;
        logic       counter_mux_sel;
        logic       count_up_down;
        logic       count_load;
        logic       count_en;
        logic       counter_reg_en;
        logic       csa_clear;
        logic [1:0] left_add_sel;
        logic [1:0] right_add_sel;
    } ctl_t;

    // A carry-save divisor is normalised once its top two bits differ
    function automatic logic is_normalised(input logic [1:0] mag);
        return (mag == 2'b01) || (mag == 2'b10);
    endfunction

endpackage

// File: rtl/srt_divider_ctrl_if.sv
// Issue-side handshake plus datapath status/control bundle of the SRT divider controller.
// master = controller side, slave = issue logic / datapath side.
interface srt_divider_ctrl_if;
    logic       start;
    logic       usigned_i;
    logic       divisor_sign;
    logic       divisor_zero;
    logic [1:0] magnitudeD;
    logic       signS;
    logic       tc;

    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       usigned;
    logic       divisor_en;
    logic       divisor_lShift;
    logic       notDivisor_en;
    logic       saveReminder;
    logic       sumHMux_sel;
    logic       sum_en;
    logic       carry_en;
    logic       leftAddMode;
    logic       rightAddMode;
    logic       QCorrectBitMux_sel;
    logic       reminder_en;
    logic       reminder_rShift;
    logic       quotient_en;
    logic       counterMux_sel;
    logic       count_upDown;
    logic       count_load;
    logic       count_en;
    logic       counterReg_en;
    logic       csa_clear;
    logic [1:0] leftAddMux_sel;
    logic [1:0] rightAddMux_sel;

    modport master (
        input  start, usigned_i, divisor_sign, divisor_zero, magnitudeD, signS, tc,
        output busy, done, div_by_zero, usigned, divisor_en, divisor_lShift, notDivisor_en,
               saveReminder, sumHMux_sel, sum_en, carry_en, leftAddMode, rightAddMode,
               QCorrectBitMux_sel, reminder_en, reminder_rShift, quotient_en, counterMux_sel,
               count_upDown, count_load, count_en, counterReg_en, csa_clear,
               leftAddMux_sel, rightAddMux_sel
    );

    modport slave (
        output start, usigned_i, divisor_sign, divisor_zero, magnitudeD, signS, tc,
        input  busy, done, div_by_zero, usigned, divisor_en, divisor_lShift, notDivisor_en,
               saveReminder, sumHMux_sel, sum_en, carry_en, leftAddMode, rightAddMode,
               QCorrectBitMux_sel, reminder_en, reminder_rShift, quotient_en, counterMux_sel,
               count_upDown, count_load, count_en, counterReg_en, csa_clear,
               leftAddMux_sel, rightAddMux_sel
    );
endinterface

// File: rtl/srt_iter_counter.sv
// Loadable down-counter with a registered zero flag; bounds both the normalisation
// shifts and the SRT iteration count.
module srt_iter_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0] count;

    // Decrement saturates at zero so a late dec never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= CW'(WIDTH - 1);
            zero  <= (WIDTH == 1);
        end else if (dec && !zero) begin
            count <= count - CW'(1);
            zero  <= (count == CW'(1));
        end
    end
endmodule

// File: rtl/srt_divider_ctrl.sv
// Control FSM sequencing the radix-2 SRT carry-save divider datapath.
// Optional feature macro: SRT_DIV_ZERO_DETECT_EN (early all-ones quotient on divide by zero).
module srt_divider_ctrl
    import srt_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    srt_divider_ctrl_if.master    bus
);
    state_t state, state_nxt;
    ctl_t   ctl;
    logic   usigned_q;
    logic   it_load, it_dec, it_zero;

    srt_iter_counter #(.WIDTH(WIDTH)) u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (it_load),
        .dec  (it_dec),
        .zero (it_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand type is captured only when a request is accepted
    always_ff @(posedge clk) begin
        if (rst)                         usigned_q <= 1'b0;
        else if (state == IDLE && bus.start) usigned_q <= bus.usigned_i;
    end

`ifdef SRT_DIV_ZERO_DETECT_EN
    logic dz_q;
    always_ff @(posedge clk) begin
        if (rst)                         dz_q <= 1'b0;
        else if (state == IDLE && bus.start) dz_q <= bus.divisor_zero;
    end
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = bus.divisor_zero;
`endif

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        it_load   = 1'b0;
        it_dec    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = CLEAR;
            CLEAR: begin
                ctl.csa_clear       = 1'b1;
                ctl.count_load      = 1'b1;
                ctl.counter_mux_sel = 1'b0;
                state_nxt           = LOAD;
`ifdef SRT_DIV_ZERO_DETECT_EN
                if (dz_q) begin
                    ctl.quotient_en    = 1'b1;
                    ctl.right_add_sel  = Q_SEL_INV;
                    ctl.right_add_mode = 1'b0;
                    state_nxt          = DONE;
                end
`endif
            end
            LOAD: begin
                ctl.divisor_en   = 1'b1;
                ctl.sum_en       = 1'b1;
                ctl.sumh_mux_sel = 1'b0;
                it_load          = 1'b1;
                state_nxt        = NORM;
            end
            // Shift until normalised; the counter caps this at WIDTH-1 shifts
            NORM: begin
                if (is_normalised(bus.magnitudeD) || it_zero) begin
                    state_nxt = NOTD;
                end else begin
                    ctl.divisor_lshift = 1'b1;
                    ctl.count_en       = 1'b1;
                    ctl.count_up_down  = 1'b1;
                    it_dec             = 1'b1;
                end
            end
            NOTD: begin
                ctl.left_add_sel   = ADD_SEL_NOTD;
                ctl.left_add_mode  = 1'b1;
                ctl.notdivisor_en  = 1'b1;
                ctl.counter_reg_en = 1'b1;
                it_load            = 1'b1;
                state_nxt          = ITER;
            end
            ITER: begin
                ctl.sumh_mux_sel = 1'b1;
                ctl.sum_en       = 1'b1;
                ctl.carry_en     = 1'b1;
                if (it_zero) state_nxt = SAVE;
                else         it_dec    = 1'b1;
            end
            SAVE: begin
                ctl.save_reminder  = 1'b1;
                ctl.left_add_sel   = ADD_SEL_CSA;
                ctl.left_add_mode  = 1'b0;
                ctl.reminder_en    = 1'b1;
                ctl.right_add_sel  = Q_SEL_CONV;
                ctl.right_add_mode = 1'b1;
                ctl.quotient_en    = 1'b1;
                state_nxt          = CHECK;
            end
            CHECK: begin
                ctl.count_load      = 1'b1;
                ctl.counter_mux_sel = 1'b1;
                state_nxt           = bus.signS ? CORR : DENORM;
            end
            // Negative partial remainder: add back D and step the quotient toward zero
            CORR: begin
                ctl.reminder_en = 1'b1;
                if (!bus.divisor_sign) begin
                    ctl.left_add_sel  = ADD_SEL_D;
                    ctl.right_add_sel = Q_SEL_CORR;
                    ctl.qcorrect_sel  = 1'b1;
                end else begin
                    ctl.left_add_sel  = ADD_SEL_NOTD_R;
                    ctl.qcorrect_sel  = 1'b0;
                end
                state_nxt = DENORM;
            end
            DENORM: begin
                if (bus.tc) begin
                    state_nxt = DONE;
                end else begin
                    ctl.reminder_rshift = 1'b1;
                    ctl.count_en        = 1'b1;
                    ctl.count_up_down   = 1'b0;
                end
            end
            DONE: begin
                ctl.done  = 1'b1;
`ifdef SRT_DIV_ZERO_DETECT_EN
                ctl.div_by_zero = dz_q;
`endif
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        ctl.busy = (state != IDLE) && (state != DONE);
    end

    assign bus.busy               = ctl.busy;
    assign bus.done               = ctl.done;
    assign bus.div_by_zero        = ctl.div_by_zero;
    assign bus.usigned            = usigned_q;
    assign bus.divisor_en         = ctl.divisor_en;
    assign bus.divisor_lShift     = ctl.divisor_lshift;
    assign bus.notDivisor_en      = ctl.notdivisor_en;
    assign bus.saveReminder       = ctl.save_reminder;
    assign bus.sumHMux_sel        = ctl.sumh_mux_sel;
    assign bus.sum_en             = ctl.sum_en;
    assign bus.carry_en           = ctl.carry_en;
    assign bus.leftAddMode        = ctl.left_add_mode;
    assign bus.rightAddMode       = ctl.right_add_mode;
    assign bus.QCorrectBitMux_sel = ctl.qcorrect_sel;
    assign bus.reminder_en        = ctl.reminder_en;
    assign bus.reminder_rShift    = ctl.reminder_rshift;
    assign bus.quotient_en        = ctl.quotient_en;
    assign bus.counterMux_sel     = ctl.counter_mux_sel;
    assign bus.count_upDown       = ctl.count_up_down;
    assign bus.count_load         = ctl.count_load;
    assign bus.count_en           = ctl.count_en;
    assign bus.counterReg_en      = ctl.counter_reg_en;
    assign bus.csa_clear          = ctl.csa_clear;
    assign bus.leftAddMux_sel     = ctl.left_add_sel;
    assign bus.rightAddMux_sel    = ctl.right_add_sel;
endmodule

// File: tb/tb_srt_divider_ctrl.sv
// Directed bench for srt_divider_ctrl: a tiny divisor/shift-counter model closes the
// magnitudeD/tc loop; sequencing, latency and mux selects are checked per operation.
module tb_srt_divider_ctrl;
    import srt_div_ctrl_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    srt_divider_ctrl_if bus();

    srt_divider_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Minimal datapath stand-in: divisor register and shift counter
    logic [31:0] d_op = '0;
    logic [31:0] dreg = '0;
    logic [5:0]  cnt  = '0;
    logic [5:0]  creg = '0;

    always @(posedge clk) begin
        if (bus.divisor_en)          dreg <= d_op;
        else if (bus.divisor_lShift) dreg <= dreg << 1;
        if (bus.count_load)          cnt  <= bus.counterMux_sel ? creg : 6'd1;
        else if (bus.count_en)       cnt  <= bus.count_upDown ? cnt + 6'd1 : cnt - 6'd1;
        if (bus.counterReg_en)       creg <= cnt;
    end

    assign bus.magnitudeD = dreg[31:30];
    assign bus.tc         = (cnt == 6'd1);

    logic [26:0] outs;
    assign outs = {bus.busy, bus.done, bus.div_by_zero, bus.usigned, bus.divisor_en,
                   bus.divisor_lShift, bus.notDivisor_en, bus.saveReminder, bus.sumHMux_sel,
                   bus.sum_en, bus.carry_en, bus.leftAddMode, bus.rightAddMode,
                   bus.QCorrectBitMux_sel, bus.reminder_en, bus.reminder_rShift,
                   bus.quotient_en, bus.counterMux_sel, bus.count_upDown, bus.count_load,
                   bus.count_en, bus.counterReg_en, bus.csa_clear,
                   bus.leftAddMux_sel, bus.rightAddMux_sel};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic run_div(input logic [31:0] d, input logic us, input logic dsign,
                           input logic ss, input int k, input int c,
                           input int spur_at, input int rst_at);
        int lat, s, lsh, rsh, it, corr, clr, busy_n, dn;
        bit fin;
        lat = 7 + 2 * k + int'(WIDTH) + c;
        s = 0; lsh = 0; rsh = 0; it = 0; corr = 0; clr = 0; busy_n = 0; dn = 0; fin = 0;
        d_op = d; bus.usigned_i = us; bus.divisor_sign = dsign; bus.signS = ss;
        bus.divisor_zero = 1'b0; bus.start = 1'b1;
        while (!fin && s < 300) begin
            @(negedge clk);
            bus.start = 1'b0;
            s++;
            if (bus.busy)                  busy_n++;
            if (bus.divisor_lShift)        lsh++;
            if (bus.reminder_rShift)       rsh++;
            if (bus.sum_en && bus.carry_en) it++;
            if (bus.csa_clear)             clr++;
            if (bus.notDivisor_en) begin
                chk("notd_lsel", 32'(bus.leftAddMux_sel), 32'(ADD_SEL_NOTD));
                chk("notd_lmode", 32'(bus.leftAddMode), 32'd1);
            end
            if (bus.saveReminder) begin
                chk("save_qen", 32'(bus.quotient_en), 32'd1);
                chk("save_rsel", 32'(bus.rightAddMux_sel), 32'(Q_SEL_CONV));
                chk("save_rmode", 32'(bus.rightAddMode), 32'd1);
            end
            if (bus.reminder_en && !bus.saveReminder) begin
                corr++;
                chk("corr_lsel", 32'(bus.leftAddMux_sel), dsign ? 32'(ADD_SEL_NOTD_R) : 32'(ADD_SEL_D));
                chk("corr_rsel", 32'(bus.rightAddMux_sel), dsign ? 32'(Q_SEL_CONV) : 32'(Q_SEL_CORR));
                chk("corr_qbit", 32'(bus.QCorrectBitMux_sel), dsign ? 32'd0 : 32'd1);
            end
            if (spur_at != 0 && s == spur_at) bus.start = 1'b1;
            if (rst_at != 0 && it == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_outs", 32'(outs), 32'd0);
                dn = 0; busy_n = 0;
                repeat (120) begin
                    @(negedge clk);
                    if (bus.done) dn++;
                    if (bus.busy) busy_n++;
                end
                chk("rst_no_done", dn, 0);
                chk("rst_idle", busy_n, 0);
                return;
            end
            if (bus.done) begin
                fin = 1'b1;
                chk("latency", s - 1, lat);
                chk("busy_cycles", busy_n, lat);
                chk("norm_shifts", lsh, k);
                chk("denorm_shifts", rsh, k);
                chk("iter_cycles", it, WIDTH);
                chk("corr_cycles", corr, c);
                chk("clear_cycles", clr, 1);
                chk("dbz_low", 32'(bus.div_by_zero), 32'd0);
                chk("usigned", 32'(bus.usigned), 32'(us));
            end
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        if (spur_at != 0) begin
            dn = 0; busy_n = 0;
            repeat (120) begin
                @(negedge clk);
                if (bus.done) dn++;
                if (bus.busy) busy_n++;
            end
            chk("spur_no_done", dn, 0);
            chk("spur_idle", busy_n, 0);
        end
    endtask

`ifdef SRT_DIV_ZERO_DETECT_EN
    task automatic run_zero();
        d_op = '0; bus.usigned_i = 1'b1; bus.divisor_sign = 1'b0; bus.signS = 1'b0;
        bus.divisor_zero = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.divisor_zero = 1'b0;
        chk("dz_clear", 32'(bus.csa_clear), 32'd1);
        chk("dz_qen", 32'(bus.quotient_en), 32'd1);
        chk("dz_rsel", 32'(bus.rightAddMux_sel), 32'(Q_SEL_INV));
        chk("dz_rmode", 32'(bus.rightAddMode), 32'd0);
        @(negedge clk);
        chk("dz_done", 32'(bus.done), 32'd1);
        chk("dz_flag", 32'(bus.div_by_zero), 32'd1);
        @(negedge clk);
        chk("dz_pulse", 32'(bus.done), 32'd0);
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.usigned_i = 1'b0; bus.divisor_sign = 1'b0;
        bus.divisor_zero = 1'b0; bus.signS = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", 32'(outs), 32'd0);

        run_div(32'd7,          1'b1, 1'b0, 1'b0, 28, 0, 0, 0);  // unsigned 100/7
        run_div(32'd7,          1'b0, 1'b0, 1'b1, 28, 1, 0, 0);  // signed -100/7, corrected
        run_div(32'd1,          1'b1, 1'b0, 1'b0, 30, 0, 0, 0);  // 0xFFFFFFFF/1
        run_div(32'hC000_0000,  1'b0, 1'b1, 1'b1,  1, 1, 0, 0);  // negative divisor, Q+1
        run_div(32'h4000_0000,  1'b0, 1'b0, 1'b1,  0, 1, 0, 0);  // already normalised
        run_div(32'd0,          1'b1, 1'b0, 1'b0, 31, 0, 0, 0);  // forced exit after WIDTH-1
        run_div(32'd7,          1'b1, 1'b0, 1'b0, 28, 0, 40, 0); // start during ITER ignored
        run_div(32'd7,          1'b1, 1'b0, 1'b0, 28, 0, 0, 10); // reset in ITER cycle 10
        run_div(32'd7,          1'b1, 1'b0, 1'b0, 28, 0, 0, 0);  // fresh start after abort
`ifdef SRT_DIV_ZERO_DETECT_EN
        run_zero();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
